// File: rtl/sync_cell_pulse_arbiter_if.sv
// rtl/sync_cell_pulse_arbiter_if.sv - requester/cell bundle for the shared sync-cell pulse arbiter
interface sync_cell_pulse_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic             cell_clk;
  logic             cell_q;
  logic             rsp_valid;
  logic [ID_W-1:0]  rsp_id;
  logic             rsp_q;
  logic             busy;
  logic             err;

  // sequencer + cell model side
  modport master (
    output req, cell_q,
    input  gnt, cell_clk, rsp_valid, rsp_id, rsp_q, busy, err
  );

  // arbiter side
  modport slave (
    input  req, cell_q,
    output gnt, cell_clk, rsp_valid, rsp_id, rsp_q, busy, err
  );
endinterface

// File: rtl/sync_cell_pulse_arbiter.sv
// rtl/sync_cell_pulse_arbiter.sv - round-robin pulse arbiter for one shared constant-output RSFQ cell
module sync_cell_pulse_arbiter #(
  parameter int N_REQ    = 4,
  parameter int ID_W     = 2,
  parameter int SETTLE   = 2,
  parameter bit EXPECT_Q = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  sync_cell_pulse_arbiter_if.slave  bus
);
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {IDLE, FIRE, WAIT, RESP} state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             cell_clk_q, cell_clk_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic             rsp_q_q, rsp_q_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  cur_q, cur_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             found;
  logic [ID_W-1:0]  winner;
  int               idx;

  // round-robin pick: first set request scanning from ptr upward, wrapping
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(ptr_q) + i) % N_REQ;
      if (!found && bus.req[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  // next state and next registered outputs; strobes default low, captured data holds
  always_comb begin
    state_d     = state_q;
    gnt_d       = '0;
    cell_clk_d  = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_q_d     = rsp_q_q;
    err_d       = err_q;
    ptr_d       = ptr_q;
    cur_d       = cur_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d       = FIRE;
          gnt_d[winner] = 1'b1;
          cell_clk_d    = 1'b1;
          cur_d         = winner;
          ptr_d         = (winner == ID_W'(N_REQ - 1)) ? '0 : winner + ID_W'(1);
        end
      end
      FIRE: begin
        state_d = WAIT;
        cnt_d   = CNT_W'(SETTLE - 1);
      end
      WAIT: begin
        if (cnt_q == '0) begin
          // the only edge at which cell_q is looked at
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_id_d    = cur_q;
          rsp_q_d     = bus.cell_q;
          if (bus.cell_q != EXPECT_Q) err_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // state and output registers; reset drops any in-flight access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      cell_clk_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_q_q     <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      ptr_q       <= '0;
      cur_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      cell_clk_q  <= cell_clk_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_q_q     <= rsp_q_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      ptr_q       <= ptr_d;
      cur_q       <= cur_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.cell_clk  = cell_clk_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_q     = rsp_q_q;
  assign bus.busy      = busy_q;
  assign bus.err       = err_q;
endmodule
